axi_chan_cut_chain: RTL



---
 rtl/axi_cut_pkg.sv | 26 ++
 rtl/axi_cut_stage.sv | 104 ++++++++++
 rtl/axi_chan_cut_chain.sv | 111 +++++++++++
 3 files changed

// File: rtl/axi_cut_pkg.sv
// Shared definitions for the AXI channel cut chain.
//   CUT_BYPASS / CUT_SPILL / CUT_FWD : MODE encodings
//   spill_state_e                    : occupancy state of one spill stage
//   cut_capacity(mode, cuts)         : number of beats a chain can hold
package axi_cut_pkg;

  localparam int CUT_BYPASS = 0;
  localparam int CUT_SPILL  = 1;
  localparam int CUT_FWD    = 2;

  // EMPTY: no entry, HALF: output entry A full, FULL: A and skid entry B full.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } spill_state_e;

  function automatic int cut_capacity(input int mode, input int cuts);
    case (mode)
      CUT_SPILL: return 2 * cuts;
      CUT_FWD:   return cuts;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/axi_cut_stage.sv
// One pipeline stage of the AXI channel cut chain.
//   MODE = CUT_SPILL : two-entry spill register, valid, data and ready all
//                      registered (ready comes straight from the state flops).
//   MODE = CUT_FWD   : one-entry forward register, ready is combinational
//                      from the downstream ready.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   valid_i/ready_o/data_i  upstream handshake and payload
//   valid_o/ready_i/data_o  downstream handshake and payload
module axi_cut_stage
  import axi_cut_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MODE       = CUT_SPILL
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  generate
    if (MODE == CUT_FWD) begin : g_fwd
      logic                  full_q;
      logic [DATA_WIDTH-1:0] data_q;

      // The entry may be refilled in the same cycle it is drained.
      assign ready_o = !full_q || ready_i;
      assign valid_o = full_q;
      assign data_o  = data_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          full_q <= 1'b0;
          data_q <= '0;
        end else if (ready_o) begin
          full_q <= valid_i;
          if (valid_i) data_q <= data_i;
        end
      end
    end else begin : g_spill
      spill_state_e          state_q, state_d;
      logic [DATA_WIDTH-1:0] a_q, b_q;
      logic                  in_hs, out_hs;

      assign in_hs  = valid_i && ready_o;
      assign out_hs = valid_o && ready_i;
      assign data_o = a_q;

      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of process ordering.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= EMPTY;
        else         state_q <= state_d;
      end

      // NOTE: default assignment first so no path leaves state_d unassigned
      // (which would infer a latch).
      always_comb begin
        state_d = state_q;
        case (state_q)
          EMPTY:   if (in_hs) state_d = HALF;
          HALF: begin
            if (in_hs && !out_hs)      state_d = FULL;
            else if (!in_hs && out_hs) state_d = EMPTY;
          end
          FULL:    if (out_hs) state_d = HALF;
          default: state_d = EMPTY;
        endcase
      end

      // Both handshake outputs decode only the state flops, so neither has a
      // combinational path from valid_i or ready_i.
      always_comb begin
        valid_o = (state_q != EMPTY);
        ready_o = (state_q != FULL);
      end

      // NOTE: payload storage is reset as well, because data_o must read 0
      // out of reset; payload registers need not normally be reset.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          case (state_q)
            EMPTY: if (in_hs) a_q <= data_i;
            HALF: begin
              if (in_hs && out_hs) a_q <= data_i;
              else if (in_hs)      b_q <= data_i;
            end
            FULL:  if (out_hs) a_q <= b_q;
            default: ;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: rtl/axi_chan_cut_chain.sv
// Chain of NUM_CUTS pipeline stages on a single AXI channel, with occupancy
// and idle reporting and an optional downstream-stall counter.
// Optional feature macro: AXI_CUT_STALL_CNT_EN (stall counter present when
// defined; stall_cnt_o tied to 0 otherwise).
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   valid_i/ready_o/data_i  upstream handshake and payload
//   valid_o/ready_i/data_o  downstream handshake and payload
//   count_o, idle_o         beats held in the chain, high when none held
//   stall_clr_i             synchronous clear of the stall counter
//   stall_cnt_o             saturating count of cycles valid_o && !ready_i
module axi_chan_cut_chain
  import axi_cut_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_CUTS   = 1,
  parameter int MODE       = CUT_SPILL,
  // Kept at least 1 bit wide so the wire-only build still has a legal port.
  parameter int CNT_W      = (NUM_CUTS > 0) ? $clog2(2 * NUM_CUTS + 1) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  idle_o,
  input  logic                  stall_clr_i,
  output logic [31:0]           stall_cnt_o
);

  // Zero capacity covers MODE 0, NUM_CUTS 0 and any unknown mode: pure wires.
  localparam int CAP = cut_capacity(MODE, NUM_CUTS);

  generate
    if (CAP == 0) begin : g_bypass
      assign valid_o = valid_i;
      assign data_o  = data_i;
      assign ready_o = ready_i;
      assign count_o = '0;
      assign idle_o  = 1'b1;
    end else begin : g_chain
      logic                  valid_s [NUM_CUTS+1];
      logic                  ready_s [NUM_CUTS+1];
      logic [DATA_WIDTH-1:0] data_s  [NUM_CUTS+1];
      logic [CNT_W-1:0]      count_q;
      logic                  in_hs, out_hs;

      assign valid_s[0]        = valid_i;
      assign data_s[0]         = data_i;
      assign ready_o           = ready_s[0];
      assign valid_o           = valid_s[NUM_CUTS];
      assign data_o            = data_s[NUM_CUTS];
      assign ready_s[NUM_CUTS] = ready_i;

      for (genvar i = 0; i < NUM_CUTS; i++) begin : g_stage
        axi_cut_stage #(
          .DATA_WIDTH (DATA_WIDTH),
          .MODE       (MODE)
        ) u_stage (
          .clk_i   (clk_i),
          .rst_ni  (rst_ni),
          .valid_i (valid_s[i]),
          .ready_o (ready_s[i]),
          .data_i  (data_s[i]),
          .valid_o (valid_s[i+1]),
          .ready_i (ready_s[i+1]),
          .data_o  (data_s[i+1])
        );
      end

      assign in_hs  = valid_i && ready_o;
      assign out_hs = valid_o && ready_i;

      // Stage back-pressure bounds the chain to CAP beats, so the counter
      // can neither overflow nor underflow.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)               count_q <= '0;
        else if (in_hs && !out_hs) count_q <= count_q + 1'b1;
        else if (out_hs && !in_hs) count_q <= count_q - 1'b1;
      end

      assign count_o = count_q;
      assign idle_o  = (count_q == '0);
    end
  endgenerate

`ifdef AXI_CUT_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Clear wins over increment; the counter sticks at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      stall_cnt_q <= '0;
    else if (stall_clr_i)
      stall_cnt_q <= '0;
    else if (valid_o && !ready_i && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_stall_clr;
  assign unused_stall_clr = stall_clr_i;
  assign stall_cnt_o      = '0;
`endif

endmodule
